v810_bus_initiator: RTL
=======================

Name: v810_bus_initiator

Overview:
- Standalone V810 external-bus master that converts a simple request/acknowledge port into V810 bus cycles.
- Bus cycles use BCYSTn/DAn/MRQn/RW/BEn/ST, a READYn wait, and SZRQn dynamic bus sizing.
- Sits beside the CPU memory unit and serves DMA engines and bench bus drivers that target the same decoded ROM/RAM/IO responders.
- Handles 16-bit responders automatically: it splits the transfer and steers the upper halfword.

Parameters:
- TIMEOUT_CYC, 255: maximum T2 wait cycles before abort. Used only when the optional feature is compiled in.

Ports:
- CLK  in  1  system clock
- RESn  in  1  reset; asynchronous, active-low
- CE  in  1  clock enable; all state advances only when CE=1
- REQ  in  1  request valid; sampled in IDLE
- REQ_A  in  32  byte address
- REQ_WR  in  1  1=write, 0=read
- REQ_BE  in  4  byte enables, active-high
- REQ_WD  in  32  write data
- REQ_ST  in  2  bus status code, copied to ST
- REQ_IO  in  1  1=I/O space (MRQn stays high), 0=memory
- ACK  out  1  one-CE-cycle completion pulse
- RD  out  32  read data; valid with ACK, held until the next acceptance
- BUSY  out  1  high from acceptance until ACK
- ERR  out  1  timeout flag, valid with ACK (feature only; tied 0 otherwise)
- A  out  32  bus address
- D_I  in  32  bus read data
- D_O  out  32  bus write data
- BEn  out  4  byte enables, active-low
- ST  out  2  bus status
- DAn  out  1  data/address strobe, active-low
- MRQn  out  1  memory request, active-low
- RW  out  1  1=read, 0=write
- BCYSTn  out  1  bus-cycle start, low for the first cycle only
- READYn  in  1  responder ready, active-low
- SZRQn  in  1  16-bit port indication, sampled with READYn

Behaviour:
- Reset (asynchronous, RESn=0) drives outputs to these values, independent of CLK:
  - BCYSTn=1, DAn=1, MRQn=1, RW=1, BEn=4'hF, A=0, D_O=0, ST=0, ACK=0, BUSY=0, ERR=0, RD=0.
  - State goes to IDLE; an in-flight cycle is abandoned with no ACK.
- States: IDLE, T1, T2, DONE.
- IDLE:
  - On CE&REQ, capture the request, set BUSY=1, go to T1 with half=LO.
  - Otherwise all bus strobes stay idle.
- T1 (one CE cycle):
  - BCYSTn=0, DAn=0, MRQn=REQ_IO, RW=~REQ_WR, ST=REQ_ST.
  - half=LO: A=REQ_A, BEn=~REQ_BE, D_O=REQ_WD.
  - half=HI: A={REQ_A[31:2],2'b10}, BEn={2'b11,~REQ_BE[3:2]}, D_O={16'h0,REQ_WD[31:16]}.
  - Next state is T2.
- T2:
  - BCYSTn=1; other strobes, A, BEn and D_O hold.
  - Stay while READYn=1.
  - On a CE edge with READYn=0:
    - Read, half=LO: RD<=D_I.
    - Read, half=HI: RD[31:16]<=D_I[15:0].
    - If SZRQn=0, half=LO and REQ_BE[3:2]!=0: go to T1 with half=HI.
    - Otherwise go to DONE.
- DONE (one CE cycle):
  - Strobes idle (DAn=1, MRQn=1, RW=1, BEn=F), ACK=1, BUSY=0.
  - Go to IDLE.
  - A REQ present during DONE is not accepted; it is accepted in the following IDLE cycle.
- Latency:
  - REQ accepted at edge n.
  - Zero-wait 32-bit access: T1 in cycle n+1, T2 in n+2, ACK in n+3.
  - Each responder wait adds one cycle.
  - A 16-bit split access adds 2 more cycles.
- Sizing rules:
  - SZRQn=1 completes in one bus cycle regardless of BE.
  - Upper-only BE on a 16-bit port takes two cycles; the first is a no-op on the device.
  - SZRQn during half=HI is ignored.
- CE=0 freezes all state and outputs; ACK stays asserted until a CE cycle passes.

Optional Feature:
- Macro: V810_BUS_INITIATOR_TIMEOUT_EN.
- When defined:
  - A counter is cleared on entry to T2 and increments per CE cycle in T2.
  - When it reaches TIMEOUT_CYC with READYn still 1, go to DONE with ERR=1 and RD=0.
  - ERR clears on the next acceptance.
- When undefined: ERR is constant 0 and T2 waits indefinitely; no counter logic exists.

Decomposition:
- Package v810_bus_pkg holds:
  - state enum (IDLE/T1/T2/DONE);
  - half enum (LO/HI);
  - ST code constants (e.g. ST_DATA=2'b10 for data access);
  - lane helper function computing BEn for a given half.
- No sub-module; the block is a single FSM plus datapath registers.

Test Plan:
- Read A=0x0000_0010, BE=F, 32-bit RAM model with zero wait -> BCYSTn low exactly one cycle, RD=model word, ACK in cycle n+3, single bus cycle.
- Write A=0x0000_0004, WD=0xDEADBEEF, BE=4'b0011, RAM with 2 waits -> D_O stable through T2, BEn=4'b1100, ACK in cycle n+5, model word low half=0xBEEF.
- Read A=0xFFF0_0000, BE=F, 16-bit ROM model (SZRQn=0, data 0x1234 then 0x5678) -> second cycle has A=0xFFF0_0002, BEn=4'b1100, RD=0x5678_1234, ACK in cycle n+5.
- RESn pulsed low during T2 of a write -> outputs take reset values immediately, no ACK; next REQ completes normally.
- Back-to-back REQ held high, with CE toggling every other clock -> second request accepted in the IDLE after DONE, and state does not advance on CE=0 clocks.
- With V810_BUS_INITIATOR_TIMEOUT_EN, TIMEOUT_CYC=8, READYn held 1 -> ACK=1, ERR=1, RD=0 after 8 T2 cycles; the following good access shows ERR=0.

Source files
------------

// File: rtl/v810_bus_initiator_pkg.sv
// v810_bus_pkg: shared types and helpers for the V810 bus initiator.
// FSM/half enums, ST codes and the byte-lane steering helper.
package v810_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    T1,
    T2,
    DONE
  } state_t;

  typedef enum logic {
    LO,
    HI
  } half_t;

  localparam logic [1:0] ST_IACK = 2'b00;
  localparam logic [1:0] ST_EXC  = 2'b01;
  localparam logic [1:0] ST_DATA = 2'b10;
  localparam logic [1:0] ST_CODE = 2'b11;

  // Upper halfword rides lanes 0/1 of a 16-bit port on the HI cycle
  function automatic logic [3:0] lane_ben(
    input logic [3:0] be,
    input half_t      h
  );
    logic [3:0] r;
    if (h == LO) r = ~be;
    else r = {2'b11, ~be[3:2]};
    return r;
  endfunction

endpackage

// File: rtl/v810_bus_initiator_if.sv
// v810_bus_initiator_if: request port plus V810 external bus.
// master = initiator side, slave = requester/responder side.
interface v810_bus_initiator_if;
  logic        REQ;
  logic [31:0] REQ_A;
  logic        REQ_WR;
  logic [3:0]  REQ_BE;
  logic [31:0] REQ_WD;
  logic [1:0]  REQ_ST;
  logic        REQ_IO;
  logic        ACK;
  logic [31:0] RD;
  logic        BUSY;
  logic        ERR;
  logic [31:0] A;
  logic [31:0] D_I;
  logic [31:0] D_O;
  logic [3:0]  BEn;
  logic [1:0]  ST;
  logic        DAn;
  logic        MRQn;
  logic        RW;
  logic        BCYSTn;
  logic        READYn;
  logic        SZRQn;

  modport master (
    input  REQ, REQ_A, REQ_WR, REQ_BE, REQ_WD, REQ_ST, REQ_IO,
    input  D_I, READYn, SZRQn,
    output ACK, RD, BUSY, ERR,
    output A, D_O, BEn, ST, DAn, MRQn, RW, BCYSTn
  );

  modport slave (
    output REQ, REQ_A, REQ_WR, REQ_BE, REQ_WD, REQ_ST, REQ_IO,
    output D_I, READYn, SZRQn,
    input  ACK, RD, BUSY, ERR,
    input  A, D_O, BEn, ST, DAn, MRQn, RW, BCYSTn
  );
endinterface

// File: rtl/v810_bus_initiator.sv
// v810_bus_initiator: V810 bus master with 16-bit dynamic sizing.
// Define V810_BUS_INITIATOR_TIMEOUT_EN to abort T2 after TIMEOUT_CYC waits.
module v810_bus_initiator
  import v810_bus_pkg::*;
`ifdef V810_BUS_INITIATOR_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYC = 255
)
`endif
(
  input logic                  CLK,
  input logic                  RESn,
  input logic                  CE,
  v810_bus_initiator_if.master bus
);

  state_t      state_q, state_d;
  half_t       half_q, half_d;
  logic [31:0] a_q, wd_q;
  logic [31:0] rd_q, rd_d;
  logic [3:0]  be_q;
  logic [1:0]  st_q;
  logic        wr_q, io_q;
  logic        take;

`ifdef V810_BUS_INITIATOR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  // State and captured request; everything holds while CE=0
  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      state_q <= IDLE;
      half_q  <= LO;
      rd_q    <= '0;
      a_q     <= '0;
      wd_q    <= '0;
      be_q    <= '0;
      st_q    <= '0;
      wr_q    <= 1'b0;
      io_q    <= 1'b0;
`ifdef V810_BUS_INITIATOR_TIMEOUT_EN
      err_q   <= 1'b0;
      cnt_q   <= '0;
`endif
    end else if (CE) begin
      state_q <= state_d;
      half_q  <= half_d;
      rd_q    <= rd_d;
      if (take) begin
        a_q  <= bus.REQ_A;
        wd_q <= bus.REQ_WD;
        be_q <= bus.REQ_BE;
        st_q <= bus.REQ_ST;
        wr_q <= bus.REQ_WR;
        io_q <= bus.REQ_IO;
      end
`ifdef V810_BUS_INITIATOR_TIMEOUT_EN
      err_q <= err_d;
      cnt_q <= cnt_d;
`endif
    end
  end

  // Next state, read-data capture and split decision
  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    rd_d    = rd_q;
    take    = 1'b0;
`ifdef V810_BUS_INITIATOR_TIMEOUT_EN
    err_d   = err_q;
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.REQ) begin
          take    = 1'b1;
          half_d  = LO;
          state_d = T1;
`ifdef V810_BUS_INITIATOR_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      T1: begin
        state_d = T2;
`ifdef V810_BUS_INITIATOR_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      T2: begin
        if (!bus.READYn) begin
          if (!wr_q) begin
            if (half_q == LO) rd_d = bus.D_I;
            else rd_d = {bus.D_I[15:0], rd_q[15:0]};
          end
          if (!bus.SZRQn && half_q == LO &&
              be_q[3:2] != 2'b00) begin
            state_d = T1;
            half_d  = HI;
          end else begin
            state_d = DONE;
          end
        end
`ifdef V810_BUS_INITIATOR_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          state_d = DONE;
          err_d   = 1'b1;
          rd_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus strobes and request-port status decoded from state
  always_comb begin
    bus.BCYSTn = 1'b1;
    bus.DAn    = 1'b1;
    bus.MRQn   = 1'b1;
    bus.RW     = 1'b1;
    bus.BEn    = 4'hF;
    bus.A      = '0;
    bus.D_O    = '0;
    bus.ST     = '0;
    bus.ACK    = (state_q == DONE);
    bus.BUSY   = (state_q == T1) || (state_q == T2);
    bus.RD     = rd_q;
`ifdef V810_BUS_INITIATOR_TIMEOUT_EN
    bus.ERR    = err_q;
`else
    bus.ERR    = 1'b0;
`endif
    if (state_q == T1 || state_q == T2) begin
      bus.BCYSTn = (state_q != T1);
      bus.DAn    = 1'b0;
      bus.MRQn   = io_q;
      bus.RW     = ~wr_q;
      bus.ST     = st_q;
      bus.BEn    = lane_ben(be_q, half_q);
      if (half_q == HI) begin
        bus.A   = {a_q[31:2], 2'b10};
        bus.D_O = {16'h0, wd_q[31:16]};
      end else begin
        bus.A   = a_q;
        bus.D_O = wd_q;
      end
    end
  end

endmodule
